// File: rtl/riscv_core_mul_pkg.sv
// Shared definitions for the RV32M iterative multiplier: control encodings,
// sequencer states and the operand magnitude helper.
package riscv_core_mul_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned MAX_XLEN = 64;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Operand widths up to MAX_XLEN; callers truncate back to their XLEN.
  function automatic logic [MAX_XLEN-1:0] mul_magnitude(input logic [MAX_XLEN-1:0] op,
                                                        input logic               neg);
    return neg ? (~op + MAX_XLEN'(1)) : op;
  endfunction

endpackage

// File: rtl/riscv_core_mul_iter.sv
// Shift-add datapath: accumulates |A|*|B| one multiplier bit per step.
// RISCV_MUL_EARLY_OUT_EN ends the sequence once no set multiplier bits remain.
module riscv_core_mul_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc,
  output logic              last_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {XLEN'(0), a_mag};
      mplier <= b_mag;
      count  <= '0;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

`ifdef RISCV_MUL_EARLY_OUT_EN
  // Finish on the step that consumes the top set bit (or immediately when none).
  assign last_c = (count == CW'(XLEN-1)) || (mplier[XLEN-1:1] == '0);
`else
  assign last_c = (count == CW'(XLEN-1));
`endif

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// Iterative RV32M multiply sequencer: operand sign/magnitude prep, handshake FSM,
// and registered result for riscv_core_mul_out. Optional RISCV_MUL_EARLY_OUT_EN.
module riscv_core_mul_ctrl
  import riscv_core_mul_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mul_ctrl_valid,
  output logic              o_mul_ctrl_ready,
  input  logic [XLEN-1:0]   i_mul_ctrl_srcA,
  input  logic [XLEN-1:0]   i_mul_ctrl_srcB,
  input  logic [1:0]        i_mul_ctrl_control,
  input  logic              i_mul_ctrl_isword,
  input  logic              i_mul_ctrl_flush,
  output logic              o_mul_ctrl_busy,
  output logic              o_mul_ctrl_valid,
  input  logic              i_mul_ctrl_ready,
  output logic [2*XLEN-1:0] o_mul_ctrl_product,
  output logic              o_mul_ctrl_srcA_Dsign,
  output logic              o_mul_ctrl_srcB_Dsign,
  output logic              o_mul_ctrl_srcA_Wsign,
  output logic              o_mul_ctrl_srcB_Wsign,
  output logic [1:0]        o_mul_ctrl_control,
  output logic              o_mul_ctrl_isword
);

  localparam int unsigned HW = XLEN / 2;

  mul_state_e state, state_nxt;

  logic            a_dsign_c, b_dsign_c, a_wsign_c, b_wsign_c;
  logic [XLEN-1:0] a_eff_c, b_eff_c, a_mag_c, b_mag_c;
  logic            accept_c, step_c, last_c, load_prod_c;
  logic            ready_nxt, busy_nxt, valid_nxt;
  logic [2*XLEN-1:0] acc;

  // Sign flags and magnitudes of the incoming operands
  always_comb begin
    a_dsign_c = i_mul_ctrl_srcA[XLEN-1] && (i_mul_ctrl_control != MULHU);
    b_dsign_c = i_mul_ctrl_srcB[XLEN-1] &&
                ((i_mul_ctrl_control == MUL) || (i_mul_ctrl_control == MULH));
    a_wsign_c = i_mul_ctrl_isword && (i_mul_ctrl_control == MUL) && i_mul_ctrl_srcA[HW-1];
    b_wsign_c = i_mul_ctrl_isword && (i_mul_ctrl_control == MUL) && i_mul_ctrl_srcB[HW-1];
    a_eff_c   = i_mul_ctrl_isword ? {{(XLEN-HW){i_mul_ctrl_srcA[HW-1]}}, i_mul_ctrl_srcA[HW-1:0]}
                                  : i_mul_ctrl_srcA;
    b_eff_c   = i_mul_ctrl_isword ? {{(XLEN-HW){i_mul_ctrl_srcB[HW-1]}}, i_mul_ctrl_srcB[HW-1:0]}
                                  : i_mul_ctrl_srcB;
    // A word operand's sign is its low-half sign; otherwise the full-width sign
    a_mag_c   = XLEN'(mul_magnitude(MAX_XLEN'(a_eff_c),
                                    i_mul_ctrl_isword ? a_wsign_c : a_dsign_c));
    b_mag_c   = XLEN'(mul_magnitude(MAX_XLEN'(b_eff_c),
                                    i_mul_ctrl_isword ? b_wsign_c : b_dsign_c));
  end

  assign accept_c = (state == IDLE) && i_mul_ctrl_valid && !i_mul_ctrl_flush;
  assign step_c   = (state == CALC) && !i_mul_ctrl_flush;

  riscv_core_mul_iter #(.XLEN(XLEN)) u_iter (
    .clk    (i_clk),
    .rst    (i_rst),
    .load   (accept_c),
    .step   (step_c),
    .a_mag  (a_mag_c),
    .b_mag  (b_mag_c),
    .acc    (acc),
    .last_c (last_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; flush wins over accept and result handshake
  always_comb begin
    state_nxt = state;
    if (i_mul_ctrl_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_mul_ctrl_valid) state_nxt = CALC;
        CALC:    if (last_c) state_nxt = DONE;
        DONE:    if (o_mul_ctrl_valid && i_mul_ctrl_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered handshake outputs
  always_comb begin
    ready_nxt   = (state_nxt == IDLE);
    busy_nxt    = (state_nxt != IDLE);
    valid_nxt   = (state == DONE) && (state_nxt == DONE);
    load_prod_c = valid_nxt && !o_mul_ctrl_valid;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mul_ctrl_ready      <= 1'b1;
      o_mul_ctrl_busy       <= 1'b0;
      o_mul_ctrl_valid      <= 1'b0;
      o_mul_ctrl_product    <= '0;
      o_mul_ctrl_srcA_Dsign <= 1'b0;
      o_mul_ctrl_srcB_Dsign <= 1'b0;
      o_mul_ctrl_srcA_Wsign <= 1'b0;
      o_mul_ctrl_srcB_Wsign <= 1'b0;
      o_mul_ctrl_control    <= 2'b00;
      o_mul_ctrl_isword     <= 1'b0;
    end else begin
      o_mul_ctrl_ready <= ready_nxt;
      o_mul_ctrl_busy  <= busy_nxt;
      o_mul_ctrl_valid <= valid_nxt;
      if (load_prod_c) o_mul_ctrl_product <= acc;
      if (accept_c) begin
        o_mul_ctrl_srcA_Dsign <= a_dsign_c;
        o_mul_ctrl_srcB_Dsign <= b_dsign_c;
        o_mul_ctrl_srcA_Wsign <= a_wsign_c;
        o_mul_ctrl_srcB_Wsign <= b_wsign_c;
        o_mul_ctrl_control    <= i_mul_ctrl_control;
        o_mul_ctrl_isword     <= i_mul_ctrl_isword;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Scoreboard bench for riscv_core_mul_ctrl: randomized and directed requests
// against an arithmetic reference model; honours RISCV_MUL_EARLY_OUT_EN latency.
module tb_riscv_core_mul_ctrl;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid, o_ready, i_flush, o_busy, o_valid, i_ready, i_isword;
  logic [XLEN-1:0]   i_srcA, i_srcB;
  logic [1:0]        i_control, o_control;
  logic [2*XLEN-1:0] o_product;
  logic              o_a_dsign, o_b_dsign, o_a_wsign, o_b_wsign, o_isword;

  typedef struct {
    logic [63:0] prod;
    logic [3:0]  sgn;
    logic [1:0]  ctl;
    logic        w;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   cons_mode = 0;
  bit   seen_first = 1'b0;

  riscv_core_mul_ctrl #(.XLEN(XLEN)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_mul_ctrl_valid      (i_valid),
    .o_mul_ctrl_ready      (o_ready),
    .i_mul_ctrl_srcA       (i_srcA),
    .i_mul_ctrl_srcB       (i_srcB),
    .i_mul_ctrl_control    (i_control),
    .i_mul_ctrl_isword     (i_isword),
    .i_mul_ctrl_flush      (i_flush),
    .o_mul_ctrl_busy       (o_busy),
    .o_mul_ctrl_valid      (o_valid),
    .i_mul_ctrl_ready      (i_ready),
    .o_mul_ctrl_product    (o_product),
    .o_mul_ctrl_srcA_Dsign (o_a_dsign),
    .o_mul_ctrl_srcB_Dsign (o_b_dsign),
    .o_mul_ctrl_srcA_Wsign (o_a_wsign),
    .o_mul_ctrl_srcB_Wsign (o_b_wsign),
    .o_mul_ctrl_control    (o_control),
    .o_mul_ctrl_isword     (o_isword)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: signed/unsigned interpretation by opcode, product of magnitudes
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] c, input logic w);
    exp_t            e;
    logic [31:0]     pa, pb;
    logic            na, nb;
    longint          sa, sbv;
    longint unsigned ma, mb;
    e.sgn[3] = a[31] && (c != 2'b11);
    e.sgn[2] = b[31] && (c == 2'b00 || c == 2'b01);
    e.sgn[1] = w && (c == 2'b00) && a[15];
    e.sgn[0] = w && (c == 2'b00) && b[15];
    pa  = w ? 32'($signed(a[15:0])) : a;
    pb  = w ? 32'($signed(b[15:0])) : b;
    na  = w ? e.sgn[1] : e.sgn[3];
    nb  = w ? e.sgn[0] : e.sgn[2];
    sa  = longint'($signed(pa));
    sbv = longint'($signed(pb));
    ma  = na ? longint'(-sa)  : {32'b0, pa};
    mb  = nb ? longint'(-sbv) : {32'b0, pb};
    e.prod = ma * mb;
    e.ctl  = c;
    e.w    = w;
    e.acc_cyc = 0;
`ifdef RISCV_MUL_EARLY_OUT_EN
    e.lat = 2;
    for (int i = 0; i < 32; i++) if (mb[i]) e.lat = 2 + i;
`else
    e.lat = 33;
`endif
    return e;
  endfunction

  // Consumer ready, changed shortly after each rising edge
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (cons_mode)
        0:       i_ready = ($urandom_range(0, 3) != 0);
        1:       i_ready = 1'b0;
        default: i_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare presented results against the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (o_busy) chk("ready_low_while_busy", 64'(o_ready), 64'd0);
      if (o_valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid: product 0x%0h with no request pending", o_product);
        end else begin
          if (!seen_first) begin
            chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
            seen_first = 1'b1;
          end
          chk("product", o_product, sb[0].prod);
          chk("sign_flags", 64'({o_a_dsign, o_b_dsign, o_a_wsign, o_b_wsign}), 64'(sb[0].sgn));
          chk("ctl_isword", 64'({o_control, o_isword}), 64'({sb[0].ctl, sb[0].w}));
          if (i_ready) begin
            void'(sb.pop_front());
            seen_first = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] c, input logic w);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      $display("FAIL issue_timeout: ready still 0 after %0d cycles", n);
      return;
    end
    i_valid = 1'b1; i_srcA = a; i_srcB = b; i_control = c; i_isword = w;
    @(posedge clk);
    #1;
    e = model(a, b, c, w);
    e.acc_cyc = cyc;
    sb.push_back(e);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          n;
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_srcA = '0; i_srcB = '0;
    i_control = 2'b00; i_isword = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_valid_busy", 64'({o_valid, o_busy}), 64'd0);
    chk("reset_product", o_product, 64'd0);
    chk("reset_flags_ctl", 64'({o_a_dsign, o_b_dsign, o_a_wsign, o_b_wsign, o_control, o_isword}), 64'd0);
    rst = 1'b0;

    issue(32'd7, 32'hFFFF_FFFD, 2'b00, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 1'b0);
    issue(32'h8000_0000, 32'h8000_0000, 2'b01, 1'b0);
    issue(32'h0000_8001, 32'h0000_7FFF, 2'b00, 1'b1);
    drain();

    // Consumer stall in DONE while a new request waits
    cons_mode = 1;
    issue(32'h0000_1234, 32'h0000_5678, 2'b00, 1'b0);
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reached_done", 64'(o_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      i_valid = 1'b1; i_srcA = $urandom; i_srcB = $urandom;
      chk("stall_ready_low", 64'(o_ready), 64'd0);
      chk("stall_valid_held", 64'(o_valid), 64'd1);
    end
    i_valid = 1'b0;
    cons_mode = 2;
    n = 0;
    while (o_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("release_ready", 64'({o_ready, o_busy, o_valid}), 64'b100);
    cons_mode = 0;

    // Flush mid-CALC with a simultaneous request
    issue(32'h0BAD_F00D, 32'hF357_9BDF, 2'b01, 1'b0);
    repeat (9) @(negedge clk);
    i_flush = 1'b1; i_valid = 1'b1; i_srcA = 32'd3; i_srcB = 32'd3;
    @(posedge clk);
    #1;
    chk("flush_idle", 64'({o_ready, o_busy, o_valid}), 64'b100);
    i_flush = 1'b0; i_valid = 1'b0;
    void'(sb.pop_back());
    issue(32'd5, 32'd5, 2'b00, 1'b0);
    issue(32'd123, 32'd0, 2'b00, 1'b0);
    issue(32'd9, 32'd4, 2'b00, 1'b0);
    drain();

    // Randomized mix, including extreme operand values
    repeat (40) begin
      case ($urandom_range(0, 4))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'((1 << $urandom_range(0, 31)));
        default: rb = $urandom;
      endcase
      issue(ra, rb, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    drain();

    // Asynchronous reset mid-CALC
    issue(32'hDEAD_BEEF, 32'h8000_0777, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_handshake", 64'({o_ready, o_busy, o_valid}), 64'b100);
    chk("midrst_product", o_product, 64'd0);
    chk("midrst_flags_ctl", 64'({o_a_dsign, o_b_dsign, o_a_wsign, o_b_wsign, o_control, o_isword}), 64'd0);
    sb.delete();
    seen_first = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(32'hFFFF_FFF9, 32'd6, 2'b00, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
